// File: rtl/noc_pkg.sv
// Shared types for the NoC link receiver: flit word layout and framing FSM states.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// The flit struct is sized by the package widths below; the receiver's
// FLIT_WIDTH / DEST_WIDTH parameters default to these and must stay equal.
package noc_pkg;

    localparam int NOC_FLIT_WIDTH   = 64;
    localparam int NOC_DEST_WIDTH   = 6;
    localparam int NOC_BUFFER_DEPTH = 4;

    typedef struct packed {
        logic [NOC_FLIT_WIDTH-1:0] data;
        logic [NOC_DEST_WIDTH-1:0] dest;
        logic                      tail;
    } noc_flit_t;

    typedef enum logic {
        RX_IDLE   = 1'b0,
        RX_IN_PKT = 1'b1
    } rx_state_e;

endpackage

// File: rtl/noc_flit_fifo.sv
// Flit buffer: DEPTH-entry circular FIFO with registered storage, no bypass.
// Latency: a push in cycle N is visible at the head (pop_vld) in cycle N+1.
// Backpressure: push accepted when not full or when a pop happens the same cycle.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   push_vld / push_dat   write request and word
//   push_acc              write actually taken this cycle
//   pop_rdy               consumer accepts the head word
//   pop_vld / pop_dat     head word present / head word
//   pop_fire              head word consumed this cycle
//   full, count           occupancy status
module noc_flit_fifo #(
    parameter int  WIDTH = 8,
    parameter int  DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_vld,
    input  logic [WIDTH-1:0] push_dat,
    output logic             push_acc,
    input  logic             pop_rdy,
    output logic             pop_vld,
    output logic [WIDTH-1:0] pop_dat,
    output logic             pop_fire,
    output logic             full,
    output logic [CNT_W-1:0] count
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;

    // Explicit wrap so non-power-of-2 depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign pop_vld  = (count != '0);
    assign pop_fire = pop_vld && pop_rdy;
    // When full, the slot being read this cycle is the one being written,
    // so a concurrent pop frees room for the push.
    assign push_acc = push_vld && (!full || pop_fire);
    // Storage is cleared on reset so the head reads 0 out of reset and stays
    // stable while empty.
    assign pop_dat  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push_acc) begin
            mem[wr_ptr] <= push_dat;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_acc) begin
                wr_ptr <= ptr_inc(wr_ptr);
            end
            if (pop_fire) begin
                rd_ptr <= ptr_inc(rd_ptr);
            end
            case ({push_acc, pop_fire})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/noc_link_receiver.sv
// Credit-based inter-router link receiver: buffers flits and re-presents them as a valid/ready stream.
// Latency: send_in in N -> flit_valid in N+1 (if empty); pop in N -> credit_out pulse in N+1.
// Backpressure: flit_ready low holds the head; upstream is throttled by withheld credits, excess flits are dropped and flagged.
//
// Ports:
//   clk_noc, rst_noc_sync                     clock, synchronous active-high reset
//   data_in, dest_in, is_tail_in, send_in     flit from the router output port
//   credit_out                                one pulse per freed buffer slot
//   flit_valid/ready/data/dest/tail           head flit stream
//   overflow_err, framing_err                 sticky error flags (cleared by reset only)
//   flit_count, pkt_count                     pop statistics, only with NOC_LINK_RX_STATS_EN
//
// Optional feature macro: NOC_LINK_RX_STATS_EN adds the flit/packet pop counters.
module noc_link_receiver
    import noc_pkg::*;
#(
    parameter int FLIT_WIDTH        = NOC_FLIT_WIDTH,
    parameter int DEST_WIDTH        = NOC_DEST_WIDTH,
    parameter int FLIT_BUFFER_DEPTH = NOC_BUFFER_DEPTH
) (
    input  logic                  clk_noc,
    input  logic                  rst_noc_sync,
    input  logic [FLIT_WIDTH-1:0] data_in,
    input  logic [DEST_WIDTH-1:0] dest_in,
    input  logic                  is_tail_in,
    input  logic                  send_in,
    output logic                  credit_out,
    output logic                  flit_valid,
    input  logic                  flit_ready,
    output logic [FLIT_WIDTH-1:0] flit_data,
    output logic [DEST_WIDTH-1:0] flit_dest,
    output logic                  flit_tail,
    output logic                  overflow_err,
    output logic                  framing_err
`ifdef NOC_LINK_RX_STATS_EN
    ,
    output logic [31:0]           flit_count,
    output logic [31:0]           pkt_count
`endif
);

    localparam int CNT_W = $clog2(FLIT_BUFFER_DEPTH + 1);

    noc_flit_t        push_flit;
    noc_flit_t        head_flit;
    logic             push_acc;
    logic             pop_fire;
    logic             fifo_full;
    logic [CNT_W-1:0] fifo_count;

    assign push_flit.data = data_in;
    assign push_flit.dest = dest_in;
    assign push_flit.tail = is_tail_in;

    noc_flit_fifo #(
        .WIDTH ($bits(noc_flit_t)),
        .DEPTH (FLIT_BUFFER_DEPTH)
    ) u_fifo (
        .clk      (clk_noc),
        .rst      (rst_noc_sync),
        .push_vld (send_in),
        .push_dat (push_flit),
        .push_acc (push_acc),
        .pop_rdy  (flit_ready),
        .pop_vld  (flit_valid),
        .pop_dat  (head_flit),
        .pop_fire (pop_fire),
        .full     (fifo_full),
        .count    (fifo_count)
    );

    assign flit_data = head_flit.data;
    assign flit_dest = head_flit.dest;
    assign flit_tail = head_flit.tail;

    // Credit return: exactly one registered pulse per pop. Buffered flits lost
    // to reset return nothing; the transmitter restores its own credits.
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            credit_out <= 1'b0;
        end else begin
            credit_out <= pop_fire;
        end
    end

    // Framing FSM tracks packets on the accepted-push side only, so dropped
    // overflow flits never move it.
    rx_state_e             state_q;
    rx_state_e             state_nxt;
    logic [DEST_WIDTH-1:0] pkt_dest_q;
    logic [DEST_WIDTH-1:0] pkt_dest_nxt;
    logic                  frame_bad;

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            state_q    <= RX_IDLE;
            pkt_dest_q <= '0;
        end else begin
            state_q    <= state_nxt;
            pkt_dest_q <= pkt_dest_nxt;
        end
    end

    always_comb begin
        state_nxt    = state_q;
        pkt_dest_nxt = pkt_dest_q;
        frame_bad    = 1'b0;
        if (push_acc) begin
            case (state_q)
                RX_IDLE: begin
                    if (!is_tail_in) begin
                        state_nxt    = RX_IN_PKT;
                        pkt_dest_nxt = dest_in;
                    end
                end
                RX_IN_PKT: begin
                    // Mismatched flit is still stored; only the flag records it.
                    frame_bad = (dest_in != pkt_dest_q);
                    if (is_tail_in) begin
                        state_nxt = RX_IDLE;
                    end
                end
                default: state_nxt = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            overflow_err <= 1'b0;
            framing_err  <= 1'b0;
        end else begin
            if (send_in && !push_acc) begin
                overflow_err <= 1'b1;
            end
            if (frame_bad) begin
                framing_err <= 1'b1;
            end
        end
    end

`ifdef NOC_LINK_RX_STATS_EN
    always_ff @(posedge clk_noc) begin
        if (rst_noc_sync) begin
            flit_count <= '0;
            pkt_count  <= '0;
        end else if (pop_fire) begin
            flit_count <= flit_count + 32'd1;
            if (head_flit.tail) begin
                pkt_count <= pkt_count + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_noc_link_receiver.sv
// Self-checking bench for noc_link_receiver: directed scenarios then random traffic against a queue model.
// Latency: n/a.
// Backpressure: random flit_ready exercises hold and drain.
module tb_noc_link_receiver;
    import noc_pkg::*;

    localparam int DEPTH = 4;

    logic        clk_noc = 1'b0;
    logic        rst_noc_sync = 1'b1;
    logic [63:0] data_in = '0;
    logic [5:0]  dest_in = '0;
    logic        is_tail_in = 1'b0;
    logic        send_in = 1'b0;
    logic        credit_out;
    logic        flit_valid;
    logic        flit_ready = 1'b0;
    logic [63:0] flit_data;
    logic [5:0]  flit_dest;
    logic        flit_tail;
    logic        overflow_err;
    logic        framing_err;
`ifdef NOC_LINK_RX_STATS_EN
    logic [31:0] flit_count;
    logic [31:0] pkt_count;
`endif

    noc_link_receiver #(
        .FLIT_WIDTH        (64),
        .DEST_WIDTH        (6),
        .FLIT_BUFFER_DEPTH (DEPTH)
    ) dut (
        .clk_noc      (clk_noc),
        .rst_noc_sync (rst_noc_sync),
        .data_in      (data_in),
        .dest_in      (dest_in),
        .is_tail_in   (is_tail_in),
        .send_in      (send_in),
        .credit_out   (credit_out),
        .flit_valid   (flit_valid),
        .flit_ready   (flit_ready),
        .flit_data    (flit_data),
        .flit_dest    (flit_dest),
        .flit_tail    (flit_tail),
        .overflow_err (overflow_err),
        .framing_err  (framing_err)
`ifdef NOC_LINK_RX_STATS_EN
        ,
        .flit_count   (flit_count),
        .pkt_count    (pkt_count)
`endif
    );

    always #5 clk_noc = ~clk_noc;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: the buffer is just a bounded queue of flits.
    noc_flit_t   m_q[$];
    logic        m_credit = 1'b0;
    logic        m_ovf    = 1'b0;
    logic        m_frm    = 1'b0;
    logic        m_in_pkt = 1'b0;
    logic [5:0]  m_pkt_dest = '0;
    int unsigned m_flits = 0;
    int unsigned m_pkts  = 0;

    task automatic model_edge(input logic rst, input logic s, input noc_flit_t f, input logic rdy);
        logic pop;
        logic accept;
        if (rst) begin
            m_q.delete();
            m_credit = 1'b0;
            m_ovf    = 1'b0;
            m_frm    = 1'b0;
            m_in_pkt = 1'b0;
            m_flits  = 0;
            m_pkts   = 0;
        end else begin
            pop    = (m_q.size() > 0) && rdy;
            accept = s && ((m_q.size() < DEPTH) || pop);
            m_credit = pop;
            if (s && !accept) m_ovf = 1'b1;
            if (pop) begin
                m_flits++;
                if (m_q[0].tail) m_pkts++;
                void'(m_q.pop_front());
            end
            if (accept) begin
                m_q.push_back(f);
                if (m_in_pkt) begin
                    if (f.dest != m_pkt_dest) m_frm = 1'b1;
                    if (f.tail) m_in_pkt = 1'b0;
                end else if (!f.tail) begin
                    m_in_pkt   = 1'b1;
                    m_pkt_dest = f.dest;
                end
            end
        end
    endtask

    task automatic check_outputs();
        check("flit_valid", 64'(flit_valid), 64'(m_q.size() > 0));
        check("credit_out", 64'(credit_out), 64'(m_credit));
        check("overflow_err", 64'(overflow_err), 64'(m_ovf));
        check("framing_err", 64'(framing_err), 64'(m_frm));
        if (m_q.size() > 0) begin
            check("flit_data", flit_data, m_q[0].data);
            check("flit_dest", 64'(flit_dest), 64'(m_q[0].dest));
            check("flit_tail", 64'(flit_tail), 64'(m_q[0].tail));
        end
`ifdef NOC_LINK_RX_STATS_EN
        check("flit_count", 64'(flit_count), 64'(m_flits));
        check("pkt_count", 64'(pkt_count), 64'(m_pkts));
`endif
    endtask

    // Called at a negedge: drive inputs, advance the model, then check after the edge.
    task automatic step(input logic rst, input logic s, input logic [63:0] d,
                        input logic [5:0] dst, input logic t, input logic rdy);
        noc_flit_t f;
        f.data = d;
        f.dest = dst;
        f.tail = t;
        rst_noc_sync = rst;
        send_in      = s;
        data_in      = d;
        dest_in      = dst;
        is_tail_in   = t;
        flit_ready   = rdy;
        model_edge(rst, s, f, rdy);
        @(posedge clk_noc);
        @(negedge clk_noc);
        check_outputs();
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_valid"}, 64'(flit_valid), 64'd0);
        check({tag, "_credit"}, 64'(credit_out), 64'd0);
        check({tag, "_ovf"}, 64'(overflow_err), 64'd0);
        check({tag, "_frm"}, 64'(framing_err), 64'd0);
        check({tag, "_data"}, flit_data, 64'd0);
        check({tag, "_dest"}, 64'(flit_dest), 64'd0);
        check({tag, "_tail"}, 64'(flit_tail), 64'd0);
    endtask

    initial begin
        @(negedge clk_noc);
        step(1, 0, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0);
        check_reset_state("rst");

        // Single flit: valid next cycle, credit one cycle after the pop.
        step(0, 1, 64'hDEAD_BEEF, 6'h05, 1, 1);
        check("single_valid", 64'(flit_valid), 64'd1);
        check("single_data", flit_data, 64'hDEAD_BEEF);
        check("single_dest", 64'(flit_dest), 64'h05);
        step(0, 0, 0, 0, 0, 1);
        check("single_credit", 64'(credit_out), 64'd1);
        step(0, 0, 0, 0, 0, 1);
        check("single_credit_once", 64'(credit_out), 64'd0);

        // Backpressure: fill with 1..4, no credits.
        for (int i = 1; i <= 4; i++) begin
            step(0, 1, 64'(i), 6'h01, 1, 0);
            check("bp_no_credit", 64'(credit_out), 64'd0);
        end
        // Full with concurrent pop: accepted, no error.
        step(0, 1, 64'd5, 6'h01, 1, 1);
        check("fullpop_no_ovf", 64'(overflow_err), 64'd0);
        check("fullpop_credit", 64'(credit_out), 64'd1);
        // Full without pop: dropped and flagged.
        step(0, 1, 64'd9, 6'h01, 1, 0);
        check("ovf_set", 64'(overflow_err), 64'd1);
        // Drain: expect 2,3,4,5 and back-to-back credits.
        for (int i = 2; i <= 5; i++) begin
            check("drain_order", flit_data, 64'(i));
            step(0, 0, 0, 0, 0, 1);
            check("drain_credit", 64'(credit_out), 64'd1);
        end
        check("drain_empty", 64'(flit_valid), 64'd0);

        // Framing: dest changes inside a packet.
        step(0, 1, 64'h10, 6'h03, 0, 1);
        check("frm_clean", 64'(framing_err), 64'd0);
        step(0, 1, 64'h11, 6'h07, 1, 1);
        check("frm_set", 64'(framing_err), 64'd1);
        step(0, 1, 64'h12, 6'h07, 1, 1);
        step(0, 0, 0, 0, 0, 1);
        step(0, 0, 0, 0, 0, 1);

        // Reset mid-operation with three flits buffered.
        for (int i = 0; i < 3; i++) step(0, 1, 64'(32'hA0 + i), 6'h02, 1, 0);
        step(1, 0, 0, 0, 0, 0);
        check_reset_state("midrst");
        step(0, 1, 64'h77, 6'h04, 1, 1);
        check("post_rst_data", flit_data, 64'h77);
        step(0, 0, 0, 0, 0, 1);
        check("post_rst_credit", 64'(credit_out), 64'd1);

        // Random traffic.
        for (int c = 0; c < 3000; c++) begin
            logic        r;
            logic        s;
            logic        rdy;
            logic [63:0] d;
            logic [5:0]  dst;
            logic        t;
            r   = ($urandom_range(0, 199) == 0);
            s   = ($urandom_range(0, 9) < 7);
            rdy = ($urandom_range(0, 9) < 6);
            d   = {$urandom, $urandom};
            dst = ($urandom_range(0, 7) == 0) ? 6'h07 : 6'h03;
            t   = ($urandom_range(0, 2) == 0);
            step(r, s, d, dst, t, rdy);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
